// File: rtl/morse_char_encoder.sv
// Serial Morse encoder for A-Z (plus 0-9 when MORSE_DIGITS_EN is defined) with a start/busy/done handshake.
// One character per start rising edge; timing in multiples of UNIT_CYCLES.
module morse_char_encoder #(
  parameter int UNIT_CYCLES      = 25000000,
  parameter int LETTER_GAP_UNITS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] letter,
  input  logic       start,
  output logic       morse_code,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] TERM     = CW'(UNIT_CYCLES - 1);
  localparam logic [2:0]    GAP_LAST = 3'(LETTER_GAP_UNITS - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, LGAP} state_t;

  // Entry layout: {valid, len[2:0], pat[4:0]}; pattern sits in the low len bits, MSB-first, 1 = dash.
  function automatic logic [8:0] rom(input logic [5:0] code);
    logic [8:0] r;
    r = '0;
    case (code)
      6'd0:  r = {1'b1, 3'd2, 5'b00001};
      6'd1:  r = {1'b1, 3'd4, 5'b01000};
      6'd2:  r = {1'b1, 3'd4, 5'b01010};
      6'd3:  r = {1'b1, 3'd3, 5'b00100};
      6'd4:  r = {1'b1, 3'd1, 5'b00000};
      6'd5:  r = {1'b1, 3'd4, 5'b00010};
      6'd6:  r = {1'b1, 3'd3, 5'b00110};
      6'd7:  r = {1'b1, 3'd4, 5'b00000};
      6'd8:  r = {1'b1, 3'd2, 5'b00000};
      6'd9:  r = {1'b1, 3'd4, 5'b00111};
      6'd10: r = {1'b1, 3'd3, 5'b00101};
      6'd11: r = {1'b1, 3'd4, 5'b00100};
      6'd12: r = {1'b1, 3'd2, 5'b00011};
      6'd13: r = {1'b1, 3'd2, 5'b00010};
      6'd14: r = {1'b1, 3'd3, 5'b00111};
      6'd15: r = {1'b1, 3'd4, 5'b00110};
      6'd16: r = {1'b1, 3'd4, 5'b01101};
      6'd17: r = {1'b1, 3'd3, 5'b00010};
      6'd18: r = {1'b1, 3'd3, 5'b00000};
      6'd19: r = {1'b1, 3'd1, 5'b00001};
      6'd20: r = {1'b1, 3'd3, 5'b00001};
      6'd21: r = {1'b1, 3'd4, 5'b00001};
      6'd22: r = {1'b1, 3'd3, 5'b00011};
      6'd23: r = {1'b1, 3'd4, 5'b01001};
      6'd24: r = {1'b1, 3'd4, 5'b01011};
      6'd25: r = {1'b1, 3'd4, 5'b01100};
`ifdef MORSE_DIGITS_EN
      6'd26: r = {1'b1, 3'd5, 5'b11111};
      6'd27: r = {1'b1, 3'd5, 5'b01111};
      6'd28: r = {1'b1, 3'd5, 5'b00111};
      6'd29: r = {1'b1, 3'd5, 5'b00011};
      6'd30: r = {1'b1, 3'd5, 5'b00001};
      6'd31: r = {1'b1, 3'd5, 5'b00000};
      6'd32: r = {1'b1, 3'd5, 5'b10000};
      6'd33: r = {1'b1, 3'd5, 5'b11000};
      6'd34: r = {1'b1, 3'd5, 5'b11100};
      6'd35: r = {1'b1, 3'd5, 5'b11110};
`else
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t        state, state_nxt;
  logic          start_q;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    units, units_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [2:0]    len_q, len_nxt;
  logic [4:0]    pat_q, pat_nxt;
  logic          err_q, err_nxt;
  logic [8:0]    entry;
  logic          start_edge;
  logic          tick;
  logic [2:0]    mark_last;
  logic [2:0]    idx_inc;

  assign start_edge = start & ~start_q;
  assign tick       = (cnt == TERM);
  // Pattern is left-aligned on acceptance, so the current element is always bit 4.
  assign mark_last  = pat_q[4] ? 3'd2 : 3'd0;
  assign idx_inc    = idx + 3'd1;
  assign entry      = rom(letter);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cnt     <= '0;
      units   <= '0;
      idx     <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      cnt     <= cnt_nxt;
      units   <= units_nxt;
      idx     <= idx_nxt;
      len_q   <= len_nxt;
      pat_q   <= pat_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    units_nxt = units;
    idx_nxt   = idx;
    len_nxt   = len_q;
    pat_nxt   = pat_q;
    err_nxt   = 1'b0;
    done      = 1'b0;

    if (state == IDLE) begin
      cnt_nxt   = '0;
      units_nxt = '0;
    end else if (tick) begin
      cnt_nxt   = '0;
      units_nxt = units + 3'd1;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start_edge) begin
          if (entry[8]) begin
            state_nxt = MARK;
            len_nxt   = entry[7:5];
            pat_nxt   = entry[4:0] << (3'd5 - entry[7:5]);
            idx_nxt   = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      MARK: begin
        if (tick && units == mark_last) begin
          units_nxt = '0;
          pat_nxt   = pat_q << 1;
          idx_nxt   = (idx < len_q) ? idx_inc : idx;
          state_nxt = (idx_inc < len_q) ? SPACE : LGAP;
        end
      end
      SPACE: begin
        if (tick) begin
          units_nxt = '0;
          state_nxt = MARK;
        end
      end
      LGAP: begin
        // done coincides with the final gap cycle; the FSM is still in LGAP here.
        if (tick && units == GAP_LAST) begin
          units_nxt = '0;
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign morse_code = (state == MARK);
  assign busy       = (state != IDLE);
  assign err        = err_q;

endmodule
